// File: rtl/note_index_finder_pkg.sv
// Shared constants, FSM encoding and note-table contents for the note index finder.
// The table maps a 4-bit index to a piano key number (0 = rest).
package note_index_finder_pkg;

  localparam int NOTE_W = 6;
  localparam int IDX_W  = 4;
  localparam int DEPTH  = 16;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // C major scale from 4C (key 40) to 5C (key 52).
  // Index 0 is the rest entry, and indices 9-15 are rest as well.
  function automatic logic [NOTE_W-1:0] note_at(input logic [IDX_W-1:0] idx);
    logic [NOTE_W-1:0] note;
    case (idx)
      4'd1:    note = 6'd40;  // 4C
      4'd2:    note = 6'd42;  // 4D
      4'd3:    note = 6'd44;  // 4E
      4'd4:    note = 6'd45;  // 4F
      4'd5:    note = 6'd47;  // 4G
      4'd6:    note = 6'd49;  // 4A
      4'd7:    note = 6'd51;  // 4B
      4'd8:    note = 6'd52;  // 5C
      default: note = NOTE_REST;
    endcase
    return note;
  endfunction

endpackage

// File: rtl/note_index_finder_rom.sv
// Note table ROM with a registered read: dout follows addr one clock later.
// The module name stays note_rom because other blocks instantiate it as-is.
module note_rom
  import note_index_finder_pkg::*;
(
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  output logic [NOTE_W-1:0] dout
);

  always_ff @(posedge clk) begin
    dout <= note_at(addr);
  end

endmodule

// File: rtl/note_index_finder.sv
// Reverse note-table lookup: accepts a key number and scans the ROM one entry per
// clock, returning the lowest matching index or a miss flag.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. note_ready is high only in IDLE; idx_valid, idx_out and miss are held
// unchanged until the edge where idx_ready is seen with idx_valid high.
module note_index_finder
  import note_index_finder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              note_valid,
  output logic              note_ready,
  output logic [IDX_W-1:0]  idx_out,
  output logic              miss,
  output logic              idx_valid,
  input  logic              idx_ready
);

  state_t            state;
  logic [NOTE_W-1:0] note_q;
  logic [IDX_W-1:0]  rom_addr;
  logic [IDX_W-1:0]  cmp_idx;
  logic              cmp_en;
  logic [NOTE_W-1:0] rom_dout;
  logic              hit;

  note_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  // rom_dout holds the entry for cmp_idx once cmp_en is set.
  assign hit        = cmp_en && (rom_dout == note_q);
  assign note_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      note_q    <= '0;
      rom_addr  <= '0;
      cmp_idx   <= '0;
      cmp_en    <= 1'b0;
      idx_out   <= '0;
      miss      <= 1'b0;
      idx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmp_en <= 1'b0;
          if (note_valid) begin
            note_q   <= note_in;
            rom_addr <= '0;
            state    <= SCAN;
          end
        end

        SCAN: begin
          rom_addr <= rom_addr + 1'b1;
          cmp_idx  <= rom_addr;
          cmp_en   <= 1'b1;
          if (hit) begin
            idx_out   <= cmp_idx;
            miss      <= 1'b0;
            idx_valid <= 1'b1;
            cmp_en    <= 1'b0;
            state     <= RESULT;
          end else if (cmp_en && (cmp_idx == LAST_IDX)) begin
            idx_out   <= '0;
            miss      <= 1'b1;
            idx_valid <= 1'b1;
            cmp_en    <= 1'b0;
            state     <= RESULT;
          end
        end

        RESULT: begin
          if (idx_ready) begin
            idx_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          idx_valid <= 1'b0;
          cmp_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule
